gb_timer: RTL and testbench
===========================

Name: gb_timer

Overview:
- Game Boy DIV/TIMA/TMA/TAC timer unit, clocked by the 4.19 MHz system clock `clk` from the prescaler.
- One `clk` cycle is one T-cycle.
- Provides the memory-mapped registers FF04–FF07 to the CPU bus decoder.
- Raises the timer interrupt request toward the interrupt controller.
- Emits the DIV-APU frame-sequencer tick toward the APU.

Parameters:
- OVF_DELAY, 4, T-cycles between TIMA overflow and the TMA reload/IRQ (one M-cycle).

Ports:
- clk  in  1  4.19 MHz system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  2  register select: 0=DIV (FF04), 1=TIMA (FF05), 2=TMA (FF06), 3=TAC (FF07).
- cpu_wr  in  1  write strobe; one-cycle write of cpu_wdata into the selected register.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  combinational read of the selected register.
- irq_timer  out  1  one-cycle pulse requesting IF bit 2.
- apu_div_tick  out  1  one-cycle pulse on the falling edge of sys_cnt[12].

Behaviour:
- State:
  - sys_cnt: 16-bit, increments by 1 every clk and wraps 0xFFFF→0x0000.
  - DIV reads sys_cnt[15:8].
  - tima, tma: 8-bit each.
  - tac: 3-bit.
  - ovf_cnt: 0..OVF_DELAY, where 0 means idle.
- Reset:
  - sys_cnt=0, tima=0, tma=0, tac=0, ovf_cnt=0.
  - irq_timer=0, apu_div_tick=0.
  - Reset mid-overflow aborts the pending reload; no IRQ is issued.
- Reads:
  - DIV returns sys_cnt[15:8].
  - TIMA returns tima.
  - TMA returns tma.
  - TAC returns {5'b11111, tac}.
- Tick source:
  - sel_bit = sys_cnt[9] / [3] / [5] / [7] for tac[1:0] = 0 / 1 / 2 / 3 (4096 / 262144 / 65536 / 16384 Hz).
  - tick_sig = tac[2] & sel_bit.
  - tick_sig is registered as tick_prev.
  - TIMA increments in any cycle where tick_prev=1 and the new tick_sig=0 (falling edge).
- Glitch rules are required for accuracy:
  - A DIV write clears sys_cnt to 0 (write data is ignored). If the selected bit was 1, this causes a falling edge and TIMA increments.
  - A TAC write that drops tick_sig from 1 to 0 (enable cleared, or a frequency change selecting a 0 bit) also increments TIMA.
- Overflow sequence:
  - An increment from 0xFF sets tima=0x00 and ovf_cnt=1.
  - While ovf_cnt is nonzero it increments each cycle.
  - In the cycle where ovf_cnt reaches OVF_DELAY: tima<=tma, irq_timer=1 for that cycle, ovf_cnt<=0.
  - TIMA therefore reads 0x00 for OVF_DELAY−1 cycles.
- Writes during overflow:
  - A TIMA write while 0<ovf_cnt<OVF_DELAY stores cpu_wdata and cancels the reload and IRQ (ovf_cnt<=0).
  - A TIMA write in the reload cycle is ignored; tma wins.
  - A TMA write in the reload cycle stores the new value in tma, and tima loads the new value (write-through).
- Simultaneous events:
  - A CPU TIMA write and a tick edge in the same cycle: the write wins and the increment is dropped.
  - A tick edge during the pending-overflow window increments tima from 0x00 normally. The overflow still completes.
- apu_div_tick: registered falling-edge detect of sys_cnt[12], including falls caused by a DIV write.
- Latency: register writes are visible on cpu_rdata in the cycle after cpu_wr.

Decomposition:
- Package gb_timer_pkg holds:
  - Register index localparams DIV_IDX, TIMA_IDX, TMA_IDX, TAC_IDX.
  - The tac_t typedef: enable bit plus 2-bit clock select.
  - TAC_UNUSED_BITS = 5'b11111.
  - The function tac_sel_bit(sys_cnt, tac) returning sel_bit.
- One sub-module, gb_falling_edge, is reused for the TIMA tick edge and the APU tick. Its ports are clk, reset, sig, fall.

Test Plan:
- Reset then free-run 1024 cycles → DIV reads 0x04; TIMA stays 0x00 (tac=0); apu_div_tick never pulses.
- Overflow and reload:
  - Stimulus: write TAC=0x05 (enable, 262144 Hz), TMA=0xF0, TIMA=0xFE; run 32 cycles.
  - First falling edge of bit 3 → TIMA=0xFF.
  - Next falling edge → TIMA=0x00, held 3 cycles.
  - 4th cycle → TIMA=0xF0 and a single irq_timer pulse.
- Reload cancel: during the same overflow, write TIMA=0x80 two cycles after the wrap → TIMA=0x80; no IRQ; no reload.
- TMA write-through: write TMA=0x33 in the reload cycle → TIMA=0x33 and IRQ asserted.
- DIV-write glitch:
  - Stimulus: TAC=0x05, TIMA=0x10; wait until sys_cnt[3]=1; write DIV.
  - Response: DIV reads 0x00 next cycle; TIMA=0x11.
  - Repeat with sys_cnt[3]=0 → TIMA stays 0x10.
- TAC-disable glitch and APU tick:
  - Stimulus: with tick_sig=1, write TAC=0x01 → TIMA increments by 1.
  - Run 16384 cycles from sys_cnt=0 → exactly 2 apu_div_tick pulses, at sys_cnt 0x2000 and 0x4000.

Source files
------------

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the Game Boy DIV/TIMA/TMA/TAC timer: register map,
// TAC layout and the helper that picks the sys_cnt bit feeding TIMA.
package gb_timer_pkg;

  localparam logic [1:0] DIV_IDX  = 2'd0;
  localparam logic [1:0] TIMA_IDX = 2'd1;
  localparam logic [1:0] TMA_IDX  = 2'd2;
  localparam logic [1:0] TAC_IDX  = 2'd3;

  localparam logic [4:0] TAC_UNUSED_BITS = 5'b11111;

  // sys_cnt bit whose falling edge drives the APU frame sequencer (512 Hz).
  localparam int APU_DIV_BIT = 12;

  typedef enum logic [1:0] {
    CLK_4096   = 2'd0,
    CLK_262144 = 2'd1,
    CLK_65536  = 2'd2,
    CLK_16384  = 2'd3
  } tac_clk_e;

  typedef struct packed {
    logic     enable;
    tac_clk_e clk_sel;
  } tac_t;

  function automatic logic tac_sel_bit(input logic [15:0] sys_cnt, input tac_t tac);
    logic bit_v;
    case (tac.clk_sel)
      CLK_4096:   bit_v = sys_cnt[9];
      CLK_262144: bit_v = sys_cnt[3];
      CLK_65536:  bit_v = sys_cnt[5];
      CLK_16384:  bit_v = sys_cnt[7];
      default:    bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/gb_falling_edge.sv
// Registered-history falling-edge detector: fall is high in the cycle where
// sig is low and was high in the previous cycle.
module gb_falling_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~sig;

endmodule

// File: rtl/gb_timer.sv
// Game Boy timer unit: free-running DIV counter, TIMA/TMA/TAC with the
// hardware's edge-detect glitches, delayed overflow reload and APU DIV tick.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int OVF_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       irq_timer,
  output logic       apu_div_tick
);

  localparam int OVF_W = $clog2(OVF_DELAY + 1);
  localparam logic [OVF_W-1:0] OVF_LAST  = OVF_W'(OVF_DELAY);
  localparam logic [OVF_W-1:0] OVF_ONE   = OVF_W'(1);

  logic [15:0]      sys_cnt_q, sys_cnt_d;
  logic [7:0]       tima_q, tima_d;
  logic [7:0]       tma_q, tma_d;
  tac_t             tac_q, tac_d;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             irq_timer_q, irq_timer_d;
  logic             apu_div_tick_q, apu_div_tick_d;

  logic             wr_div, wr_tima, wr_tma, wr_tac;
  logic             tick_sig_d;
  logic             tick_fall;
  logic             apu_fall;
  logic             ovf_pending;
  logic             ovf_reload;
  logic [OVF_W-1:0] ovf_cnt_inc;

  // CPU bus: cpu_wr is a single-cycle strobe with no back-pressure; the write
  // is taken on the rising edge where it is high and reads back next cycle.
  always_comb begin
    wr_div  = cpu_wr && (cpu_addr == DIV_IDX);
    wr_tima = cpu_wr && (cpu_addr == TIMA_IDX);
    wr_tma  = cpu_wr && (cpu_addr == TMA_IDX);
    wr_tac  = cpu_wr && (cpu_addr == TAC_IDX);
  end

  always_comb begin
    sys_cnt_d = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
    tma_d     = wr_tma ? cpu_wdata : tma_q;
    tac_d     = wr_tac ? tac_t'(cpu_wdata[2:0]) : tac_q;
  end

  // Edges are taken on next-state values so DIV and TAC writes glitch TIMA
  // in the same cycle the write lands.
  always_comb begin
    tick_sig_d = tac_d.enable & tac_sel_bit(sys_cnt_d, tac_d);
  end

  gb_falling_edge u_tick_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (tick_sig_d),
    .fall  (tick_fall)
  );

  gb_falling_edge u_apu_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (sys_cnt_d[APU_DIV_BIT]),
    .fall  (apu_fall)
  );

  always_comb begin
    apu_div_tick_d = apu_fall;
  end

  // Reload beats a CPU TIMA write, which beats a tick increment.
  always_comb begin
    ovf_pending = (ovf_cnt_q != '0);
    ovf_cnt_inc = ovf_cnt_q + OVF_ONE;
    ovf_reload  = ovf_pending && (ovf_cnt_inc == OVF_LAST);

    tima_d      = tima_q;
    ovf_cnt_d   = ovf_pending ? ovf_cnt_inc : '0;
    irq_timer_d = 1'b0;

    if (ovf_reload) begin
      tima_d      = tma_d;
      ovf_cnt_d   = '0;
      irq_timer_d = 1'b1;
    end else if (wr_tima) begin
      tima_d    = cpu_wdata;
      ovf_cnt_d = '0;
    end else if (tick_fall) begin
      if (tima_q == 8'hFF) begin
        tima_d    = 8'h00;
        ovf_cnt_d = OVF_ONE;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sys_cnt_q      <= 16'h0000;
      tima_q         <= 8'h00;
      tma_q          <= 8'h00;
      tac_q          <= tac_t'(3'b000);
      ovf_cnt_q      <= '0;
      irq_timer_q    <= 1'b0;
      apu_div_tick_q <= 1'b0;
    end else begin
      sys_cnt_q      <= sys_cnt_d;
      tima_q         <= tima_d;
      tma_q          <= tma_d;
      tac_q          <= tac_d;
      ovf_cnt_q      <= ovf_cnt_d;
      irq_timer_q    <= irq_timer_d;
      apu_div_tick_q <= apu_div_tick_d;
    end
  end

  always_comb begin
    case (cpu_addr)
      DIV_IDX:  cpu_rdata = sys_cnt_q[15:8];
      TIMA_IDX: cpu_rdata = tima_q;
      TMA_IDX:  cpu_rdata = tma_q;
      TAC_IDX:  cpu_rdata = {TAC_UNUSED_BITS, tac_q};
      default:  cpu_rdata = 8'h00;
    endcase
  end

  assign irq_timer    = irq_timer_q;
  assign apu_div_tick = apu_div_tick_q;

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: directed scenarios plus random register traffic, all
// checked every cycle against a counter-based reference model.
module tb_gb_timer;
  import gb_timer_pkg::*;

  localparam int OVF_DELAY = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cpu_addr;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       irq_timer;
  logic       apu_div_tick;

  gb_timer #(.OVF_DELAY(OVF_DELAY)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wr       (cpu_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .irq_timer    (irq_timer),
    .apu_div_tick (apu_div_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int irq_seen = 0;
  int apu_seen = 0;
  logic [9:0] exp_q[$];
  logic [7:0] apu_div_log[$];
  logic [9:0] mon_e;

  // ---------------- reference model ----------------
  int         m_cnt;
  logic [7:0] m_tima;
  logic [7:0] m_tma;
  logic [2:0] m_tac;
  int         m_wait;   // cycles left reading 0x00 before the reload lands
  logic       m_irq;
  logic       m_apu;
  int shift_tbl[4] = '{9, 3, 5, 7};

  function automatic logic tick_of(input int cnt, input logic [2:0] tac);
    return tac[2] && (((cnt >> shift_tbl[tac[1:0]]) & 1) == 1);
  endfunction

  function automatic logic [9:0] exp_now(input logic [1:0] a);
    logic [7:0] rd;
    case (a)
      2'd0:    rd = 8'((m_cnt >> 8) & 255);
      2'd1:    rd = m_tima;
      2'd2:    rd = m_tma;
      default: rd = {5'b11111, m_tac};
    endcase
    return {rd, m_irq, m_apu};
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    int         n_cnt;
    int         n_wait;
    logic [2:0] n_tac;
    logic [7:0] n_tma;
    logic [7:0] n_tima;
    logic       fall;
    if (r) begin
      m_cnt = 0; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
      m_wait = 0; m_irq = 1'b0; m_apu = 1'b0;
    end else begin
      n_cnt  = (w && a == 2'd0) ? 0 : (m_cnt + 1) % 65536;
      n_tac  = (w && a == 2'd3) ? d[2:0] : m_tac;
      n_tma  = (w && a == 2'd2) ? d : m_tma;
      fall   = tick_of(m_cnt, m_tac) && !tick_of(n_cnt, n_tac);
      m_apu  = (((m_cnt >> 12) & 1) == 1) && (((n_cnt >> 12) & 1) == 0);
      m_irq  = 1'b0;
      n_tima = m_tima;
      n_wait = (m_wait > 0) ? m_wait - 1 : 0;
      if (m_wait == 1) begin
        n_tima = n_tma;
        m_irq  = 1'b1;
      end else if (w && a == 2'd1) begin
        n_tima = d;
        n_wait = 0;
      end else if (fall) begin
        if (m_tima == 8'hFF) begin
          n_tima = 8'h00;
          n_wait = OVF_DELAY - 1;
        end else begin
          n_tima = m_tima + 8'd1;
        end
      end
      m_cnt = n_cnt; m_tac = n_tac; m_tma = n_tma; m_tima = n_tima; m_wait = n_wait;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({cpu_rdata, irq_timer, apu_div_tick} !== mon_e) begin
        bad++;
        $display("FAIL scoreboard t=%0t addr=%0d got rdata=%02h irq=%b apu=%b expected rdata=%02h irq=%b apu=%b",
                 $time, cpu_addr, cpu_rdata, irq_timer, apu_div_tick, mon_e[9:2], mon_e[1], mon_e[0]);
      end
    end
    if (irq_timer === 1'b1) irq_seen++;
    if (apu_div_tick === 1'b1) begin
      apu_seen++;
      if (cpu_addr == DIV_IDX) apu_div_log.push_back(cpu_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    reset = r; cpu_wr = w; cpu_addr = a; cpu_wdata = d;
    exp_q.push_back(exp_now(a));
    model_step(r, w, a, d);
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input logic [1:0] a);
    cyc(1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, got, expv);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic peek(input logic [1:0] a, input string name, input logic [7:0] expv);
    reset = 1'b0; cpu_wr = 1'b0; cpu_addr = a; cpu_wdata = 8'h00;
    exp_q.push_back(exp_now(a));
    model_step(1'b0, 1'b0, a, 8'h00);
    @(negedge clk);
    check8(name, cpu_rdata, expv);
    @(posedge clk); #1;
  endtask

  task automatic wait_phase16(input int v, input string name);
    int g = 0;
    while ((m_cnt % 16) != v && g < 64) begin idle(TIMA_IDX); g++; end
    if ((m_cnt % 16) != v) timeout(name);
  endtask

  task automatic wait_ovf(input int v, input string name);
    int g = 0;
    while (m_wait != v && g < 80) begin idle(TIMA_IDX); g++; end
    if (m_wait != v) timeout(name);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int irq0;
    int apu0;
    int g;
    reset = 1'b1; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    model_step(1'b1, 1'b0, 2'd0, 8'h00);

    // reset state and free run
    apu0 = apu_seen;
    peek(TAC_IDX, "reset_tac", 8'hF8);
    peek(TIMA_IDX, "reset_tima", 8'h00);
    repeat (1022) idle(2'($urandom_range(0, 3)));
    peek(DIV_IDX, "div_after_1024", 8'h04);
    peek(TIMA_IDX, "tima_idle_tac0", 8'h00);
    check_int("apu_none_1024", apu_seen - apu0, 0);

    // overflow and reload
    wr_reg(TAC_IDX, 8'h05);
    wr_reg(TMA_IDX, 8'hF0);
    wr_reg(TIMA_IDX, 8'hFE);
    irq0 = irq_seen;
    g = 0;
    while (irq_seen == irq0 && g < 64) begin idle(TIMA_IDX); g++; end
    if (irq_seen == irq0) timeout("reload_irq_wait");
    peek(TIMA_IDX, "reload_tima", 8'hF0);
    check_int("reload_irq_count", irq_seen - irq0, 1);

    // reload cancelled by a TIMA write in the pending window
    wr_reg(TIMA_IDX, 8'hFE);
    wait_ovf(OVF_DELAY - 1, "cancel_wrap_wait");
    irq0 = irq_seen;
    idle(TIMA_IDX);
    wr_reg(TIMA_IDX, 8'h80);
    repeat (6) idle(TIMA_IDX);
    peek(TIMA_IDX, "cancel_tima", 8'h80);
    check_int("cancel_no_irq", irq_seen - irq0, 0);

    // TMA write in the reload cycle writes through to TIMA
    wr_reg(TIMA_IDX, 8'hFE);
    wait_ovf(1, "wt_reload_wait");
    irq0 = irq_seen;
    wr_reg(TMA_IDX, 8'h33);
    peek(TIMA_IDX, "writethrough_tima", 8'h33);
    check_int("writethrough_irq", irq_seen - irq0, 1);
    peek(TMA_IDX, "writethrough_tma", 8'h33);

    // reset in the middle of an overflow aborts it
    wr_reg(TIMA_IDX, 8'hFE);
    wait_ovf(2, "rst_ovf_wait");
    irq0 = irq_seen;
    cyc(1'b1, 1'b0, TIMA_IDX, 8'h00);
    repeat (6) idle(TIMA_IDX);
    check_int("reset_ovf_no_irq", irq_seen - irq0, 0);
    peek(TIMA_IDX, "reset_ovf_tima", 8'h00);

    // DIV write with selected bit high glitches TIMA
    wr_reg(TAC_IDX, 8'h05);
    wait_phase16(0, "div_glitch_align1");
    wr_reg(TIMA_IDX, 8'h10);
    repeat (7) idle(TIMA_IDX);
    wr_reg(DIV_IDX, 8'hA5);
    peek(DIV_IDX, "div_write_clears", 8'h00);
    peek(TIMA_IDX, "div_glitch_inc", 8'h11);

    // DIV write with selected bit low leaves TIMA alone
    wait_phase16(0, "div_glitch_align2");
    wr_reg(TIMA_IDX, 8'h10);
    repeat (3) idle(TIMA_IDX);
    wr_reg(DIV_IDX, 8'h00);
    peek(DIV_IDX, "div_write_clears2", 8'h00);
    peek(TIMA_IDX, "div_noglitch", 8'h10);

    // TAC disable while tick_sig is high glitches TIMA
    wait_phase16(0, "tac_glitch_align");
    wr_reg(TIMA_IDX, 8'h20);
    repeat (7) idle(TIMA_IDX);
    wr_reg(TAC_IDX, 8'h01);
    peek(TIMA_IDX, "tac_glitch_inc", 8'h21);
    peek(TAC_IDX, "tac_readback", 8'hF9);

    // APU frame tick over 16384 cycles from sys_cnt=0
    g = 0;
    while (((m_cnt >> 12) & 1) == 1 && g < 8200) begin idle(DIV_IDX); g++; end
    if (((m_cnt >> 12) & 1) == 1) timeout("apu_align");
    wr_reg(DIV_IDX, 8'h00);
    apu0 = apu_seen;
    apu_div_log.delete();
    repeat (16385) idle(DIV_IDX);
    check_int("apu_pulse_count", apu_seen - apu0, 2);
    if (apu_div_log.size() == 2) begin
      check8("apu_first_div", apu_div_log[0], 8'h20);
      check8("apu_second_div", apu_div_log[1], 8'h40);
    end

    // random register traffic
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      r = ($urandom_range(0, 1499) == 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (w && a == TIMA_IDX && $urandom_range(0, 1) == 1) d = 8'($urandom_range(252, 255));
      if (w && a == TAC_IDX) d[2] = ($urandom_range(0, 3) != 0);
      cyc(r, w, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
